// File: rtl/symbol_framer.sv
// Serial-bit to 2-bit symbol framer: pairs incoming bits, queues symbols in a
// small FIFO and presents one symbol per SYM_LEN-cycle period to the modulator.
module symbol_framer #(
  parameter int         SYM_LEN    = 128,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] IDLE_SYM   = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] sym_out,
  output logic       sym_start,
  output logic       underrun,
  output logic       active
);
  localparam int            CW       = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST     = CW'(SYM_LEN - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          r_pend, r_hi, r_live;
  logic [1:0]    r_sym;
  logic          r_start, r_under, r_active;

  logic w_full, w_acc, w_push, w_pop, w_boundary;

  // r_live keeps bit_ready low until the first edge after reset is released.
  assign w_full     = (r_count == FULL_CNT);
  assign bit_ready  = r_live && !(r_pend && w_full);
  assign w_acc      = bit_valid && bit_ready;
  assign w_push     = w_acc && r_pend;
  assign w_boundary = (r_cnt == LAST);
  assign w_pop      = w_boundary && (r_count != '0);

  assign sym_out   = r_sym;
  assign sym_start = r_start;
  assign underrun  = r_under;
  assign active    = r_active;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_hi, bit_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_pend   <= 1'b0;
      r_hi     <= 1'b0;
      r_live   <= 1'b0;
      r_sym    <= IDLE_SYM;
      r_start  <= 1'b0;
      r_under  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_cnt   <= w_boundary ? '0 : r_cnt + CW'(1);
      r_start <= w_boundary;
      r_under <= w_boundary && !w_pop;

      // Pop decision uses the pre-edge count, so a same-edge push waits a period.
      if (w_boundary) begin
        r_sym    <= w_pop ? r_mem[r_rp] : IDLE_SYM;
        r_active <= w_pop;
      end

      if (w_acc) begin
        if (!r_pend) begin
          r_hi   <= bit_in;
          r_pend <= 1'b1;
        end else begin
          r_pend <= 1'b0;
        end
      end

      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_symbol_framer.sv
// Bench for symbol_framer: two instances (default and SYM_LEN=4/FIFO_DEPTH=2)
// checked cycle by cycle against a queue-based behavioural model.
module tb_symbol_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, vld, bin, rdy, st, ur, act;
  logic [1:0] so_a, so_b;

  symbol_framer u_a (
    .clk(clk), .reset(rst[0]), .bit_in(bin[0]), .bit_valid(vld[0]),
    .bit_ready(rdy[0]), .sym_out(so_a), .sym_start(st[0]),
    .underrun(ur[0]), .active(act[0])
  );

  symbol_framer #(.SYM_LEN(4), .FIFO_DEPTH(2), .IDLE_SYM(2'd0)) u_b (
    .clk(clk), .reset(rst[1]), .bit_in(bin[1]), .bit_valid(vld[1]),
    .bit_ready(rdy[1]), .sym_out(so_b), .sym_start(st[1]),
    .underrun(ur[1]), .active(act[1])
  );

  wire [5:0] obs_a = {so_a, act[0], st[0], ur[0], rdy[0]};
  wire [5:0] obs_b = {so_b, act[1], st[1], ur[1], rdy[1]};

  int checks = 0;
  int errors = 0;

  // Reference model: period position, symbol queue packed head-first in mq.
  int          mcnt [2];
  int          msz  [2];
  logic [31:0] mq   [2];
  logic        mpend[2], mhi[2], mlive[2];
  logic [1:0]  esym [2];
  logic        eact [2], est[2], eund[2];
  logic        m_acc, m_pop;

  function automatic int slen(input int k);
    return (k == 0) ? 128 : 4;
  endfunction

  function automatic int depth(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic mready(input int k);
    return mlive[k] && !(mpend[k] && msz[k] == depth(k));
  endfunction

  function automatic logic [5:0] expv(input int k);
    return {esym[k], eact[k], est[k], eund[k], mready(k)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_acc = vld[k] && mready(k);
      if (rst[k]) begin
        mcnt[k] = 0; msz[k] = 0; mq[k] = '0; mpend[k] = 1'b0; mhi[k] = 1'b0;
        mlive[k] = 1'b0; esym[k] = 2'd0; eact[k] = 1'b0; est[k] = 1'b0; eund[k] = 1'b0;
      end else begin
        est[k] = 1'b0; eund[k] = 1'b0; m_pop = 1'b0;
        if (mcnt[k] == slen(k) - 1) begin
          est[k] = 1'b1;
          if (msz[k] > 0) begin
            esym[k] = mq[k][1:0]; eact[k] = 1'b1; m_pop = 1'b1;
          end else begin
            esym[k] = 2'd0; eact[k] = 1'b0; eund[k] = 1'b1;
          end
          mcnt[k] = 0;
        end else begin
          mcnt[k] = mcnt[k] + 1;
        end
        if (m_pop) begin
          mq[k] = mq[k] >> 2;
          msz[k] = msz[k] - 1;
        end
        if (m_acc) begin
          if (!mpend[k]) begin
            mhi[k] = bin[k]; mpend[k] = 1'b1;
          end else begin
            mq[k][2*msz[k] +: 2] = {mhi[k], bin[k]};
            msz[k] = msz[k] + 1;
            mpend[k] = 1'b0;
          end
        end
        mlive[k] = 1'b1;
      end
    end
  end

  logic sa[$];
  logic sb[$];

  // One clock: drive at the falling edge, return at the next falling edge.
  task automatic step(input logic ea, input logic eb);
    logic acc_a, acc_b;
    vld[0] = ea && (sa.size() > 0);
    bin[0] = (sa.size() > 0) ? sa[0] : 1'b0;
    vld[1] = eb && (sb.size() > 0);
    bin[1] = (sb.size() > 0) ? sb[0] : 1'b0;
    acc_a  = vld[0] && mready(0);
    acc_b  = vld[1] && mready(1);
    @(posedge clk);
    @(negedge clk);
    if (acc_a) void'(sa.pop_front());
    if (acc_b) void'(sb.pop_front());
    vld = 2'b00;
  endtask

  task automatic reset_a();
    sa.delete();
    rst[0] = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst[0] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    checks++;
    if (obs_a !== 6'b00_0_0_0_0) begin
      errors++; $display("FAIL reset_state got %b want %b", obs_a, 6'b0);
    end
    checks++;
    if (obs_a !== expv(0)) begin
      errors++; $display("FAIL reset_model got %b want %b", obs_a, expv(0));
    end
    rst[0] = 1'b0;
  endtask

  task automatic test_idle();
    for (int t = 1; t <= 3 * 128; t++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL idle_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
      checks++;
      if (st[0] !== (t % 128 == 0)) begin
        errors++; $display("FAIL idle_start t=%0d got %b want %b", t, st[0], (t % 128 == 0));
      end
      if (t % 128 == 0) begin
        checks++;
        if ({ur[0], so_a, act[0]} !== 4'b1_00_0) begin
          errors++; $display("FAIL idle_underrun t=%0d got %b want 1000", t, {ur[0], so_a, act[0]});
        end
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] tbl [5];
    tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    reset_a();
    sa = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int t = 1; t <= 5 * 128; t++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL seq_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
      if (t >= 128) begin
        checks++;
        if (so_a !== tbl[(t - 128) / 128]) begin
          errors++; $display("FAIL seq_sym t=%0d got %0d want %0d", t, so_a, tbl[(t - 128) / 128]);
        end
      end
      if (t == 512) begin
        checks++;
        if ({st[0], ur[0], act[0]} !== 3'b110) begin
          errors++; $display("FAIL seq_underrun got %b want 110", {st[0], ur[0], act[0]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       bits[20];
    logic [1:0] got[$];
    reset_a();
    for (int i = 0; i < 20; i++) begin
      bits[i] = 1'($urandom_range(0, 1));
      sa.push_back(bits[i]);
    end
    for (int t = 1; t <= 11 * 128; t++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL bp_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
      if (t == 20 || t == 127 || t == 128) begin
        checks++;
        if (rdy[0] !== (t == 128)) begin
          errors++; $display("FAIL bp_ready t=%0d got %b want %b", t, rdy[0], (t == 128));
        end
      end
      if (st[0] === 1'b1 && act[0] === 1'b1) got.push_back(so_a);
    end
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL bp_count got %0d want 10", got.size());
    end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {bits[2*i], bits[2*i+1]}) begin
        errors++; $display("FAIL bp_sym i=%0d got %0d want %0d", i, got[i], {bits[2*i], bits[2*i+1]});
      end
    end
  endtask

  task automatic test_boundary_push();
    reset_a();
    sa = '{1'b1, 1'b0};
    for (int t = 1; t <= 256; t++) begin
      step((t == 5) || (t == 128), 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL bnd_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
      if (t == 128) begin
        checks++;
        if ({st[0], ur[0], act[0], so_a} !== 5'b110_00) begin
          errors++; $display("FAIL bnd_idle got %b want 11000", {st[0], ur[0], act[0], so_a});
        end
      end
      if (t == 256) begin
        checks++;
        if ({st[0], ur[0], act[0], so_a} !== 5'b101_10) begin
          errors++; $display("FAIL bnd_pair got %b want 10110", {st[0], ur[0], act[0], so_a});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_a();
    sa = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 1; t <= 150; t++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL mid_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
    end
    rst[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs_a !== 6'b00_0_0_0_0) begin
        errors++; $display("FAIL mid_reset i=%0d got %b want 000000", i, obs_a);
      end
    end
    rst[0] = 1'b0;
    for (int t = 1; t <= 256; t++) begin
      if (t == 129) sa = '{1'b0, 1'b1};
      step(1'b1, 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL mid_model2 t=%0d got %b want %b", t, obs_a, expv(0));
      end
      if (t == 128) begin
        checks++;
        if ({st[0], ur[0], so_a} !== 4'b11_00) begin
          errors++; $display("FAIL mid_first got %b want 1100", {st[0], ur[0], so_a});
        end
      end
      if (t == 256) begin
        checks++;
        if ({st[0], act[0], so_a} !== 4'b11_01) begin
          errors++; $display("FAIL mid_fresh got %b want 1101", {st[0], act[0], so_a});
        end
      end
    end
  endtask

  task automatic test_small();
    int low = 0;
    rst[1] = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst[1] = 1'b0;
    for (int i = 0; i < 30; i++) sb.push_back(1'($urandom_range(0, 1)));
    for (int t = 1; t <= 60; t++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs_b !== expv(1)) begin
        errors++; $display("FAIL small_model t=%0d got %b want %b", t, obs_b, expv(1));
      end
      checks++;
      if (st[1] !== (t % 4 == 0)) begin
        errors++; $display("FAIL small_period t=%0d got %b want %b", t, st[1], (t % 4 == 0));
      end
      if (t > 1 && rdy[1] === 1'b0) low++;
    end
    checks++;
    if (low == 0) begin
      errors++; $display("FAIL small_backpressure got 0 low cycles want >0");
    end
  endtask

  task automatic test_random();
    reset_a();
    for (int t = 1; t <= 2000; t++) begin
      while (sa.size() < 2) sa.push_back(1'($urandom_range(0, 1)));
      rst[0] = (t == 1000);
      step(1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL rand_model t=%0d got %b want %b", t, obs_a, expv(0));
      end
    end
    rst[0] = 1'b0;
  endtask

  initial begin
    rst = 2'b11;
    vld = 2'b00;
    bin = 2'b00;
    test_reset();
    test_idle();
    test_sequence();
    test_back_to_back();
    test_boundary_push();
    test_reset_mid();
    test_small();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
